eeprom_access_arbiter: RTL and testbench
========================================

Name: eeprom_access_arbiter

Overview:
- Shares the single I2C EEPROM read/write engine between two independent requesters (req0, req1) using round-robin arbitration.
- Sequences each single-byte access: one-cycle WR/RD strobe, holds ADDR/DATA stable until engine ACK, returns read data and a completion pulse.
- Enforces a post-write gap covering the EEPROM internal write cycle.
- Watchdog recovers a hung engine via a local engine reset.
- Sits between system masters and the engine; top level builds engine DATA inout as eng_data_oe ? eng_data_out : 8'hzz, with eng_data_in = DATA.

Parameters:
- WR_GAP_CYCLES, 10000, idle CLK cycles enforced after a write ACK before the next grant (>=1).
- TIMEOUT_CYCLES, 4096, max CLK cycles in WAIT_ACK before the watchdog fires (>=16).
- CNT_W, 16, counter width; must hold max(WR_GAP_CYCLES, TIMEOUT_CYCLES).

Ports:
- CLK  in  1  system clock, same clock as engine.
- RESET  in  1  synchronous, active-high.
- reqN_valid  in  1  (N=0,1) request pending; held until accepted.
- reqN_we  in  1  1=write, 0=read.
- reqN_addr  in  11  EEPROM byte address.
- reqN_wdata  in  8  write data.
- reqN_ready  out  1  combinational accept; transfer on valid&ready.
- reqN_done  out  1  one-cycle completion pulse.
- reqN_err  out  1  valid with done; 1=timeout.
- reqN_rdata  out  8  read data; valid with done, held until next done to that port.
- eng_wr, eng_rd  out  1  engine strobes.
- eng_addr  out  11  engine ADDR.
- eng_data_out  out  8  engine DATA drive value.
- eng_data_oe  out  1  drive enable for engine DATA.
- eng_data_in  in  8  engine DATA sampled value.
- eng_ack  in  1  engine completion pulse.
- eng_rst  out  1  engine reset; ORed with RESET at top level.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values: all registered outputs 0, reqN_rdata 8'h00, state IDLE, last_grant=1, so req0 wins the first tie.
- reqN_ready is 1 only in IDLE for the winner:
  - sole valid requester wins;
  - if both valid, winner is the port != last_grant.
  - At most one ready high per cycle.
- Accept, cycle T: latch port id, we, addr, wdata; last_grant<=id; next state ISSUE.
- ISSUE (1 cycle, T+1):
  - eng_wr=we or eng_rd=~we high for exactly this cycle;
  - eng_addr valid from T+1 until leaving WAIT_ACK;
  - on write, eng_data_oe=1 with eng_data_out=wdata from T+1 until ack;
  - next WAIT_ACK, counter cleared.
- Strobes are never high outside ISSUE; the engine restarts if a strobe is seen after it returns to idle.
- WAIT_ACK: counter increments each cycle.
  - On eng_ack=1 at cycle A:
    - read: rdata<=eng_data_in sampled at A;
    - pulse done for latched port at A+1, err=0;
    - drop oe at A+1;
    - write -> WR_GAP, read -> IDLE.
  - If counter reaches TIMEOUT_CYCLES-1 without ack -> RECOVER.
  - eng_ack outside WAIT_ACK is ignored.
- WR_GAP: count WR_GAP_CYCLES cycles, ready held low, then IDLE.
- RECOVER:
  - eng_rst=1 for exactly 2 cycles; oe, wr, rd = 0;
  - done=1, err=1, rdata unchanged at the first RECOVER cycle;
  - then IDLE with no write gap.
- ACK coinciding with the timeout terminal count: ACK wins.
- RESET mid-transaction: immediate return to IDLE, no done pulse, eng_rst=0. The engine is reset by the same RESET.
- Requester deasserting valid before accept: legal, nothing issued.

Decomposition:
- Shared package eeprom_arb_pkg:
  - state enum {IDLE, ISSUE, WAIT_ACK, WR_GAP, RECOVER};
  - constants EE_ADDR_W=11, EE_DATA_W=8, EE_RST_CYCLES=2.
- One natural sub-module, rr_arb2: 2-way round-robin grant (valid[1:0], last_grant, en -> grant one-hot). Counter stays inline.

Test Plan:
- Single write: req0 write addr 11'h123 data 8'hA5.
  - Expect eng_wr pulse 1 cycle, eng_addr=11'h123, eng_data_out=8'hA5 with oe until ack.
  - Expect req0_done 1 cycle after ack with err=0.
  - Expect no grant for WR_GAP_CYCLES (model set to 20).
- Single read: req1 read addr 11'h7FF, engine model returns 8'h3C with ack.
  - Expect req1_rdata=8'h3C at req1_done, eng_rd pulse 1 cycle, oe never high.
- Contention: both valid at the same cycle after reset.
  - Expect grant order req0, req1, req0, req1 over 4 back-to-back reads.
  - Expect ready never high on both ports in one cycle.
- Timeout: model never acks (TIMEOUT_CYCLES=32).
  - Expect RECOVER at 32 cycles after ISSUE, eng_rst high exactly 2 cycles.
  - Expect done=1, err=1, then next request served normally.
- Ack on terminal count: ack arrives exactly at cycle TIMEOUT_CYCLES-1 -> err=0, eng_rst stays 0.
- Reset mid-op: RESET asserted during WAIT_ACK.
  - Expect all outputs 0 next cycle, no done.
  - Expect req0 wins the following tie.

Source files
------------

// File: rtl/eeprom_arb_pkg.sv
// Shared types and constants for the two-port EEPROM access arbiter.
package eeprom_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WR_GAP,
    RECOVER
  } arb_state_e;

  localparam int EE_ADDR_W     = 11;
  localparam int EE_DATA_W     = 8;
  localparam int EE_RST_CYCLES = 2;

endpackage

// File: rtl/eeprom_access_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the port not granted last.
module rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  input  logic       en_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    if (en_i) begin
      if (valid_i == 2'b11) grant_o = last_grant_i ? 2'b01 : 2'b10;
      else                  grant_o = valid_i;
    end
  end

endmodule

// File: rtl/eeprom_access_arbiter.sv
// Shares one I2C EEPROM byte engine between two requesters, with write-cycle gap and hang recovery.
module eeprom_access_arbiter
  import eeprom_arb_pkg::*;
#(
  parameter int WR_GAP_CYCLES  = 10000,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 req0_valid,
  input  logic                 req0_we,
  input  logic [EE_ADDR_W-1:0] req0_addr,
  input  logic [EE_DATA_W-1:0] req0_wdata,
  output logic                 req0_ready,
  output logic                 req0_done,
  output logic                 req0_err,
  output logic [EE_DATA_W-1:0] req0_rdata,
  input  logic                 req1_valid,
  input  logic                 req1_we,
  input  logic [EE_ADDR_W-1:0] req1_addr,
  input  logic [EE_DATA_W-1:0] req1_wdata,
  output logic                 req1_ready,
  output logic                 req1_done,
  output logic                 req1_err,
  output logic [EE_DATA_W-1:0] req1_rdata,
  output logic                 eng_wr,
  output logic                 eng_rd,
  output logic [EE_ADDR_W-1:0] eng_addr,
  output logic [EE_DATA_W-1:0] eng_data_out,
  output logic                 eng_data_oe,
  input  logic [EE_DATA_W-1:0] eng_data_in,
  input  logic                 eng_ack,
  output logic                 eng_rst,
  output logic                 busy
);

  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(WR_GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(EE_RST_CYCLES - 1);

  arb_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 id_q, id_d;
  logic                 last_q, last_d;
  logic                 we_q, we_d;
  logic [EE_ADDR_W-1:0] addr_q, addr_d;
  logic [EE_DATA_W-1:0] wdata_q, wdata_d;
  logic [EE_DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                 done0_q, done0_d, done1_q, done1_d;
  logic                 err0_q, err0_d, err1_q, err1_d;
  logic [1:0]           grant;
  logic                 accept;
  logic                 active;

  rr_arb2 u_arb (
    .valid_i      ({req1_valid, req0_valid}),
    .last_grant_i (last_q),
    .en_i         (state_q == IDLE),
    .grant_o      (grant)
  );

  assign accept = |(grant & {req1_valid, req0_valid});

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    id_d     = id_q;
    last_d   = last_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    err0_d   = 1'b0;
    err1_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          id_d    = grant[1];
          last_d  = grant[1];
          we_d    = grant[1] ? req1_we    : req0_we;
          addr_d  = grant[1] ? req1_addr  : req0_addr;
          wdata_d = grant[1] ? req1_wdata : req0_wdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        // An ack on the terminal count still completes normally.
        if (eng_ack) begin
          if (!we_q) begin
            if (id_q) rdata1_d = eng_data_in;
            else      rdata0_d = eng_data_in;
          end
          done0_d = ~id_q;
          done1_d = id_q;
          cnt_d   = '0;
          state_d = we_q ? WR_GAP : IDLE;
        end else if (cnt_q == TO_LAST) begin
          done0_d = ~id_q;
          done1_d = id_q;
          err0_d  = ~id_q;
          err1_d  = id_q;
          cnt_d   = '0;
          state_d = RECOVER;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WR_GAP: begin
        if (cnt_q == GAP_LAST) state_d = IDLE;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      RECOVER: begin
        if (cnt_q == RST_LAST) state_d = IDLE;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      id_q     <= 1'b0;
      last_q   <= 1'b1;
      rdata0_q <= '0;
      rdata1_q <= '0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      id_q     <= id_d;
      last_q   <= last_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
    end
  end

  // Request payload is only observed while the state machine is active, so it needs no reset.
  always_ff @(posedge CLK) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  assign active       = (state_q == ISSUE) || (state_q == WAIT_ACK);
  assign eng_wr       = (state_q == ISSUE) && we_q;
  assign eng_rd       = (state_q == ISSUE) && !we_q;
  assign eng_addr     = active ? addr_q : '0;
  assign eng_data_oe  = active && we_q;
  assign eng_data_out = eng_data_oe ? wdata_q : '0;
  assign eng_rst      = (state_q == RECOVER);
  assign busy         = (state_q != IDLE);

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign req0_done  = done0_q;
  assign req1_done  = done1_q;
  assign req0_err   = err0_q;
  assign req1_err   = err1_q;
  assign req0_rdata = rdata0_q;
  assign req1_rdata = rdata1_q;

endmodule

// File: tb/tb_eeprom_access_arbiter.sv
// Randomized bench for eeprom_access_arbiter against a transaction-level model of ports, arbitration and EEPROM.
module tb_eeprom_access_arbiter;

  localparam int WR_GAP  = 20;
  localparam int TIMEOUT = 32;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        req0_valid = 1'b0, req0_we = 1'b0;
  logic [10:0] req0_addr = '0;
  logic [7:0]  req0_wdata = '0;
  logic        req1_valid = 1'b0, req1_we = 1'b0;
  logic [10:0] req1_addr = '0;
  logic [7:0]  req1_wdata = '0;
  logic        req0_ready, req0_done, req0_err;
  logic [7:0]  req0_rdata;
  logic        req1_ready, req1_done, req1_err;
  logic [7:0]  req1_rdata;
  logic        eng_wr, eng_rd, eng_data_oe, eng_rst, busy;
  logic [10:0] eng_addr;
  logic [7:0]  eng_data_out;
  logic [7:0]  eng_data_in = '0;
  logic        eng_ack = 1'b0;

  int vectors = 0;
  int errors  = 0;

  // Reference model state: last granted port, EEPROM contents, expected held read data.
  int          model_last;
  logic [7:0]  mem [2048];
  logic [7:0]  rd_exp [2];

  eeprom_access_arbiter #(
    .WR_GAP_CYCLES  (WR_GAP),
    .TIMEOUT_CYCLES (TIMEOUT),
    .CNT_W          (16)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .req0_valid   (req0_valid),
    .req0_we      (req0_we),
    .req0_addr    (req0_addr),
    .req0_wdata   (req0_wdata),
    .req0_ready   (req0_ready),
    .req0_done    (req0_done),
    .req0_err     (req0_err),
    .req0_rdata   (req0_rdata),
    .req1_valid   (req1_valid),
    .req1_we      (req1_we),
    .req1_addr    (req1_addr),
    .req1_wdata   (req1_wdata),
    .req1_ready   (req1_ready),
    .req1_done    (req1_done),
    .req1_err     (req1_err),
    .req1_rdata   (req1_rdata),
    .eng_wr       (eng_wr),
    .eng_rd       (eng_rd),
    .eng_addr     (eng_addr),
    .eng_data_out (eng_data_out),
    .eng_data_oe  (eng_data_oe),
    .eng_data_in  (eng_data_in),
    .eng_ack      (eng_ack),
    .eng_rst      (eng_rst),
    .busy         (busy)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (!RESET) begin
      vectors++;
      if (req0_ready && req1_ready) begin
        errors++;
        $display("FAIL ready_exclusive: ready0=%b ready1=%b, required at most one high", req0_ready, req1_ready);
      end
    end
  end

  function automatic logic rdy(input int p);
    return (p == 0) ? req0_ready : req1_ready;
  endfunction

  function automatic logic dn(input int p);
    return (p == 0) ? req0_done : req1_done;
  endfunction

  function automatic logic er(input int p);
    return (p == 0) ? req0_err : req1_err;
  endfunction

  function automatic logic [7:0] rd(input int p);
    return (p == 0) ? req0_rdata : req1_rdata;
  endfunction

  task automatic set_req(input int p, input logic v, input logic we, input logic [10:0] a, input logic [7:0] d);
    if (p == 0) begin
      req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
    end
  endtask

  // One complete transaction from a lone requester; delay<0 means the engine never acks.
  task automatic do_txn(input int p, input logic we, input logic [10:0] addr, input logic [7:0] wd, input int delay);
    logic acked;
    acked = 1'b0;
    set_req(p, 1'b1, we, addr, wd);
    #1;
    vectors++;
    if (rdy(p) !== 1'b1 || rdy(1 - p) !== 1'b0) begin
      errors++;
      $display("FAIL accept_ready port%0d: ready=%b other=%b, required 1 and 0", p, rdy(p), rdy(1 - p));
    end
    @(negedge CLK);
    model_last = p;
    set_req(p, 1'b0, 1'b0, 11'($urandom), 8'($urandom));
    vectors++;
    if (eng_wr !== we || eng_rd !== !we || eng_addr !== addr || eng_data_oe !== we || (we && eng_data_out !== wd)) begin
      errors++;
      $display("FAIL issue: wr=%b rd=%b addr=%h oe=%b dout=%h, required wr=%b rd=%b addr=%h oe=%b dout=%h",
               eng_wr, eng_rd, eng_addr, eng_data_oe, eng_data_out, we, !we, addr, we, wd);
    end
    for (int k = 0; k < TIMEOUT; k++) begin
      @(negedge CLK);
      vectors++;
      if (eng_wr !== 1'b0 || eng_rd !== 1'b0 || eng_addr !== addr || eng_data_oe !== we ||
          (we && eng_data_out !== wd) || busy !== 1'b1 || eng_rst !== 1'b0) begin
        errors++;
        $display("FAIL wait_ack cyc%0d: wr=%b rd=%b addr=%h oe=%b dout=%h busy=%b rst=%b, required 0 0 %h %b %h 1 0",
                 k, eng_wr, eng_rd, eng_addr, eng_data_oe, eng_data_out, busy, eng_rst, addr, we, wd);
      end
      if (k == delay) begin
        eng_ack = 1'b1;
        eng_data_in = we ? 8'($urandom) : mem[addr];
        acked = 1'b1;
        break;
      end
    end
    @(negedge CLK);
    eng_ack = 1'b0;
    eng_data_in = 8'($urandom);
    if (acked) begin
      if (we) mem[addr] = wd;
      else    rd_exp[p] = mem[addr];
      vectors++;
      if (dn(p) !== 1'b1 || er(p) !== 1'b0 || dn(1 - p) !== 1'b0 || rd(p) !== rd_exp[p] ||
          eng_data_oe !== 1'b0 || eng_rst !== 1'b0) begin
        errors++;
        $display("FAIL done port%0d: done=%b err=%b other_done=%b rdata=%h oe=%b rst=%b, required 1 0 0 %h 0 0",
                 p, dn(p), er(p), dn(1 - p), rd(p), eng_data_oe, eng_rst, rd_exp[p]);
      end
      if (we) begin
        for (int g = 0; g < WR_GAP; g++) begin
          set_req(p, 1'b1, 1'b0, 11'($urandom), 8'($urandom));
          eng_ack = 1'($urandom);
          #1;
          vectors++;
          if (rdy(p) !== 1'b0 || busy !== 1'b1 || (g > 0 && (req0_done || req1_done))) begin
            errors++;
            $display("FAIL write_gap cyc%0d: ready=%b busy=%b done0=%b done1=%b, required 0 1 no done",
                     g, rdy(p), busy, req0_done, req1_done);
          end
          @(negedge CLK);
        end
        eng_ack = 1'b0;
        #1;
        vectors++;
        if (rdy(p) !== 1'b1) begin
          errors++;
          $display("FAIL gap_end_ready port%0d: ready=%b, required 1", p, rdy(p));
        end
        set_req(p, 1'b0, 1'b0, 11'($urandom), 8'($urandom));
        @(negedge CLK);
        vectors++;
        if (busy !== 1'b0 || eng_wr !== 1'b0 || eng_rd !== 1'b0) begin
          errors++;
          $display("FAIL withdraw: busy=%b wr=%b rd=%b, required 0 0 0", busy, eng_wr, eng_rd);
        end
      end else begin
        vectors++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL read_idle: busy=%b, required 0", busy);
        end
      end
    end else begin
      vectors++;
      if (eng_rst !== 1'b1 || dn(p) !== 1'b1 || er(p) !== 1'b1 || rd(p) !== rd_exp[p] ||
          eng_data_oe !== 1'b0 || eng_wr !== 1'b0 || eng_rd !== 1'b0) begin
        errors++;
        $display("FAIL recover1 port%0d: rst=%b done=%b err=%b rdata=%h oe=%b wr=%b rd=%b, required 1 1 1 %h 0 0 0",
                 p, eng_rst, dn(p), er(p), rd(p), eng_data_oe, eng_wr, eng_rd, rd_exp[p]);
      end
      @(negedge CLK);
      vectors++;
      if (eng_rst !== 1'b1 || dn(p) !== 1'b0) begin
        errors++;
        $display("FAIL recover2: rst=%b done=%b, required 1 0", eng_rst, dn(p));
      end
      @(negedge CLK);
      vectors++;
      if (eng_rst !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL recover_exit: rst=%b busy=%b, required 0 0", eng_rst, busy);
      end
    end
  endtask

  task automatic test_reset;
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    vectors++;
    if ({busy, eng_wr, eng_rd, eng_data_oe, eng_rst, req0_done, req1_done, req0_err, req1_err} !== 9'b0 ||
        eng_addr !== 11'h000 || eng_data_out !== 8'h00 || req0_rdata !== 8'h00 || req1_rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: busy=%b wr=%b rd=%b oe=%b rst=%b addr=%h rdata0=%h rdata1=%h, required all 0",
               busy, eng_wr, eng_rd, eng_data_oe, eng_rst, eng_addr, req0_rdata, req1_rdata);
    end
    RESET = 1'b0;
    model_last = 1;
    rd_exp[0] = 8'h00;
    rd_exp[1] = 8'h00;
    @(negedge CLK);
  endtask

  task automatic test_contention;
    logic [10:0] a [2];
    for (int p = 0; p < 2; p++) begin
      a[p] = 11'($urandom);
      set_req(p, 1'b1, 1'b0, a[p], 8'h00);
    end
    #1;
    for (int i = 0; i < 4; i++) begin
      int w;
      w = 1 - model_last;
      vectors++;
      if (rdy(w) !== 1'b1 || rdy(1 - w) !== 1'b0) begin
        errors++;
        $display("FAIL contention_grant%0d: ready0=%b ready1=%b, required winner port%0d", i, req0_ready, req1_ready, w);
      end
      @(negedge CLK);
      model_last = w;
      set_req(w, 1'b0, 1'b0, a[w], 8'h00);
      vectors++;
      if (eng_rd !== 1'b1 || eng_addr !== a[w]) begin
        errors++;
        $display("FAIL contention_issue%0d: rd=%b addr=%h, required 1 %h", i, eng_rd, eng_addr, a[w]);
      end
      @(negedge CLK);
      eng_ack = 1'b1;
      eng_data_in = mem[a[w]];
      @(negedge CLK);
      eng_ack = 1'b0;
      rd_exp[w] = mem[a[w]];
      vectors++;
      if (dn(w) !== 1'b1 || dn(1 - w) !== 1'b0 || rd(w) !== rd_exp[w]) begin
        errors++;
        $display("FAIL contention_done%0d: done=%b other=%b rdata=%h, required 1 0 %h", i, dn(w), dn(1 - w), rd(w), rd_exp[w]);
      end
      a[w] = 11'($urandom);
      set_req(w, 1'b1, 1'b0, a[w], 8'h00);
      #1;
    end
    set_req(0, 1'b0, 1'b0, 11'h000, 8'h00);
    set_req(1, 1'b0, 1'b0, 11'h000, 8'h00);
    @(negedge CLK);
  endtask

  task automatic test_single_write;
    do_txn(0, 1'b1, 11'h123, 8'hA5, int'($urandom_range(0, 5)));
  endtask

  task automatic test_single_read;
    mem[11'h7FF] = 8'h3C;
    do_txn(1, 1'b0, 11'h7FF, 8'h00, 3);
    vectors++;
    if (req1_rdata !== 8'h3C) begin
      errors++;
      $display("FAIL read_7ff: rdata1=%h, required 3c", req1_rdata);
    end
  endtask

  task automatic test_timeout;
    do_txn(0, 1'b0, 11'($urandom), 8'h00, -1);
    do_txn(1, 1'b1, 11'($urandom), 8'($urandom), 2);
    do_txn(0, 1'b1, 11'($urandom), 8'($urandom), -1);
  endtask

  task automatic test_ack_terminal;
    do_txn(1, 1'b0, 11'($urandom), 8'h00, TIMEOUT - 1);
    do_txn(0, 1'b1, 11'($urandom), 8'($urandom), TIMEOUT - 1);
  endtask

  task automatic test_random;
    for (int i = 0; i < 12; i++)
      do_txn(int'($urandom_range(0, 1)), 1'($urandom), 11'($urandom), 8'($urandom), int'($urandom_range(0, 6)));
  endtask

  task automatic test_reset_midop;
    logic [10:0] a;
    a = 11'($urandom);
    set_req(1, 1'b1, 1'b0, a, 8'h00);
    #1;
    @(negedge CLK);
    set_req(1, 1'b0, 1'b0, a, 8'h00);
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    vectors++;
    if ({busy, eng_wr, eng_rd, eng_data_oe, eng_rst, req0_done, req1_done} !== 7'b0 ||
        eng_addr !== 11'h000 || req0_rdata !== 8'h00 || req1_rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_midop: busy=%b wr=%b rd=%b oe=%b rst=%b done0=%b done1=%b addr=%h, required all 0",
               busy, eng_wr, eng_rd, eng_data_oe, eng_rst, req0_done, req1_done, eng_addr);
    end
    RESET = 1'b0;
    model_last = 1;
    rd_exp[0] = 8'h00;
    rd_exp[1] = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      vectors++;
      if (req0_done !== 1'b0 || req1_done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_quiet%0d: done0=%b done1=%b busy=%b, required 0 0 0", i, req0_done, req1_done, busy);
      end
    end
    set_req(0, 1'b1, 1'b0, 11'($urandom), 8'h00);
    set_req(1, 1'b1, 1'b0, 11'($urandom), 8'h00);
    #1;
    vectors++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_tie: ready0=%b ready1=%b, required 1 0", req0_ready, req1_ready);
    end
    set_req(0, 1'b0, 1'b0, 11'h000, 8'h00);
    set_req(1, 1'b0, 1'b0, 11'h000, 8'h00);
    @(negedge CLK);
    do_txn(0, 1'b0, 11'($urandom), 8'h00, 1);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
    test_reset;
    test_contention;
    test_single_write;
    test_single_read;
    test_timeout;
    test_ack_terminal;
    test_random;
    test_reset_midop;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
